uart_fifo_drain: RTL
====================

UART_FIFO_DRAIN -- requirements
Module: uart_fifo_drain

Interface
REQ-001 The block SHALL have parameter PAUSE, default 0, giving the idle clk cycles inserted after each UART byte completes.
REQ-002 The block SHALL have parameter ERR_BASE, default 8'h30 ("0"), giving the base code of error report bytes.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port enable  input  1  permits the start of new transfers.
REQ-006 The block SHALL have port fifo_data_available  input  1  FIFO holds at least one word.
REQ-007 The block SHALL have port fifo_read_data  input  8  FIFO head word, valid while fifo_data_available=1.
REQ-008 The block SHALL have port fifo_read_strobe  output  1  one-cycle pulse that pops the FIFO head.
REQ-009 The block SHALL have port fifo_werror  input  1  FIFO overflow pulse.
REQ-010 The block SHALL have port fifo_rerror  input  1  FIFO underflow pulse.
REQ-011 The block SHALL have port uart_data  output  8  byte to transmit.
REQ-012 The block SHALL have port uart_data_strobe  output  1  one-cycle load pulse to the UART transmitter.
REQ-013 The block SHALL have port uart_ready  input  1  UART transmitter is idle.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port byte_count  output  16  bytes handed to the UART since reset; wraps 16'hFFFF->0.

Function
REQ-016 The state machine SHALL have the states IDLE, LOAD, WAIT_BUSY, WAIT_DONE and GAP; all outputs SHALL be registered.
REQ-017 fifo_werror/fifo_rerror pulses SHALL set sticky flags werr/rerr in any state, including the cycle the flags are cleared; set wins over clear.
REQ-018 In IDLE with uart_ready=1 and (werr|rerr)=1, the next cycle SHALL be LOAD with uart_data=ERR_BASE+{werr,rerr}, and werr/rerr cleared; fifo_read_strobe stays 0.
REQ-019 Error reports SHALL be sent regardless of enable and SHALL take priority over FIFO data.
REQ-020 Otherwise, in IDLE with enable=1, fifo_data_available=1 and uart_ready=1, the next cycle SHALL be LOAD with uart_data=fifo_read_data sampled in IDLE.
REQ-021 In LOAD, uart_data_strobe SHALL be 1 for exactly one cycle; fifo_read_strobe SHALL be 1 in that same cycle for data bytes only; byte_count SHALL increment by 1.
REQ-022 Latency SHALL be 1 cycle from the IDLE start condition to the strobe.
REQ-023 LOAD SHALL always go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL move to WAIT_DONE on uart_ready=0, or after 4 cycles with uart_ready=1 (lost-load guard).
REQ-025 WAIT_DONE SHALL move on uart_ready=1: to GAP if PAUSE>0, else to IDLE.
REQ-026 GAP SHALL count PAUSE cycles (counter width clog2(PAUSE+1)), then go to IDLE.
REQ-027 uart_data SHALL hold its value from LOAD until the next LOAD.
REQ-028 Deasserting enable mid-byte SHALL NOT abort the byte; the block returns to IDLE and starts no further data bytes.
REQ-029 Back-to-back bytes SHALL be separated by at least the UART frame time plus PAUSE; FIFO pops SHALL never exceed one per byte sent.
REQ-030 fifo_read_strobe SHALL never assert while fifo_data_available was 0 at the IDLE decision.

Reset
REQ-031 reset=0 SHALL immediately force: state IDLE; fifo_read_strobe=0; uart_data_strobe=0; uart_data=8'h00; busy=0; byte_count=0; werr=rerr=0; GAP counter=0.
REQ-032 Reset asserted mid-byte SHALL abandon the byte with no further strobes; operation SHALL resume from IDLE on the first clk edge after release.

Verification
REQ-033 FIFO preloaded with 8'h41,8'h42,8'h43, enable=1, UART model at 3 Mb/s from 96 MHz -> UART receives "ABC" in order, 3 pops, byte_count=3.
REQ-034 fifo_werror pulse while a data byte is in flight, FIFO non-empty -> next byte sent is 8'h32 ("2"), then FIFO data resumes; no pop for the error byte.
REQ-035 fifo_werror and fifo_rerror pulsed in the same cycle, enable=0 -> one byte 8'h33 ("3") sent; busy returns to 0.
REQ-036 PAUSE=5, two FIFO bytes -> exactly 5 idle cycles between uart_ready rising and the second uart_data_strobe (plus 1-cycle IDLE decision).
REQ-037 UART model never drops uart_ready after the strobe -> WAIT_BUSY exits after 4 cycles; no deadlock; next byte proceeds.
REQ-038 reset=0 asserted in WAIT_DONE, then released -> all outputs 0 immediately, byte_count=0, the next transfer starts cleanly from IDLE.

Source files
------------

// File: rtl/uart_fifo_drain.sv
// uart_fifo_drain
//   Drains bytes from a FIFO into a UART transmitter one byte at a time. Pending
//   FIFO overflow/underflow events are reported as a single byte
//   (ERR_BASE + {werr, rerr}). Error bytes go ahead of FIFO data and do not need
//   enable.
//
// Ports
//   clk                 in   1   clock, all state changes on rising edge
//   reset               in   1   asynchronous active-low reset
//   enable              in   1   permits new data transfers to start
//   fifo_data_available in   1   FIFO holds at least one word
//   fifo_read_data      in   8   FIFO head word
//   fifo_read_strobe    out  1   one-cycle pop of the FIFO head
//   fifo_werror         in   1   FIFO overflow pulse
//   fifo_rerror         in   1   FIFO underflow pulse
//   uart_data           out  8   byte to transmit, held until the next load
//   uart_data_strobe    out  1   one-cycle load pulse to the UART
//   uart_ready          in   1   UART transmitter idle
//   busy                out  1   high in every state except idle
//   byte_count          out  16  bytes handed to the UART since reset (wraps)

module uart_fifo_drain #(
    parameter int unsigned PAUSE    = 0,
    parameter logic [7:0]  ERR_BASE = 8'h30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_data_available,
    input  logic [7:0]  fifo_read_data,
    output logic        fifo_read_strobe,
    input  logic        fifo_werror,
    input  logic        fifo_rerror,
    output logic [7:0]  uart_data,
    output logic        uart_data_strobe,
    input  logic        uart_ready,
    output logic        busy,
    output logic [15:0] byte_count
);

    localparam int unsigned GapW = (PAUSE > 0) ? $clog2(PAUSE + 1) : 1;
    // Only reachable when PAUSE > 0.
    localparam logic [GapW-1:0] GapLast = GapW'(PAUSE - 32'd1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone,
        StGap
    } state_t;

    state_t          r_state;
    logic            r_fifo_read_strobe;
    logic            r_uart_data_strobe;
    logic [7:0]      r_uart_data;
    logic            r_busy;
    logic [15:0]     r_byte_count;
    logic            r_werr;
    logic            r_rerr;
    logic [1:0]      r_wait_cnt;
    logic [GapW-1:0] r_gap_cnt;

    logic w_err_pending;
    logic w_start_err;
    logic w_start_data;

    assign w_err_pending = r_werr | r_rerr;
    assign w_start_err   = (r_state == StIdle) & uart_ready & w_err_pending;
    assign w_start_data  = (r_state == StIdle) & uart_ready & ~w_err_pending &
                           enable & fifo_data_available;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= StIdle;
            r_fifo_read_strobe <= 1'b0;
            r_uart_data_strobe <= 1'b0;
            r_uart_data        <= 8'h00;
            r_busy             <= 1'b0;
            r_byte_count       <= 16'h0000;
            r_werr             <= 1'b0;
            r_rerr             <= 1'b0;
            r_wait_cnt         <= 2'd0;
            r_gap_cnt          <= '0;
        end else begin
            // A pulse landing on the clearing cycle must not be lost: set wins.
            r_werr <= fifo_werror | (r_werr & ~w_start_err);
            r_rerr <= fifo_rerror | (r_rerr & ~w_start_err);

            r_uart_data_strobe <= 1'b0;
            r_fifo_read_strobe <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_start_err) begin
                        r_state            <= StLoad;
                        r_uart_data        <= ERR_BASE + {6'd0, r_werr, r_rerr};
                        r_uart_data_strobe <= 1'b1;
                        r_byte_count       <= r_byte_count + 16'd1;
                        r_busy             <= 1'b1;
                    end else if (w_start_data) begin
                        r_state            <= StLoad;
                        r_uart_data        <= fifo_read_data;
                        r_uart_data_strobe <= 1'b1;
                        r_fifo_read_strobe <= 1'b1;
                        r_byte_count       <= r_byte_count + 16'd1;
                        r_busy             <= 1'b1;
                    end
                end
                StLoad: begin
                    r_state    <= StWaitBusy;
                    r_wait_cnt <= 2'd0;
                end
                StWaitBusy: begin
                    // Give up waiting for the UART to go busy after 4 cycles so a
                    // lost load cannot hang the drain.
                    if (!uart_ready || r_wait_cnt == 2'd3) begin
                        r_state <= StWaitDone;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                StWaitDone: begin
                    if (uart_ready) begin
                        if (PAUSE > 0) begin
                            r_state   <= StGap;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GapLast) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GapW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read_strobe = r_fifo_read_strobe;
    assign uart_data_strobe = r_uart_data_strobe;
    assign uart_data        = r_uart_data;
    assign busy             = r_busy;
    assign byte_count       = r_byte_count;

endmodule
